pipe_stage_reg: RTL

- Parametrised pipeline-stage register for the ARMv8 pipeline. Generalises the 1-bit synchronous-reset flop to a WIDTH-bit stage with valid/ready handshake, stall support, flush (bubble insertion) and an optional skid entry.
- Sits between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- With SKID=1 it fully breaks both the data path and the ready path combinationally while sustaining 1 transfer/cycle.

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, stall, flush and an
// optional skid entry. With SKID=1 both the data and the ready path are
// registered while still sustaining one transfer per cycle; with SKID=0 the
// stage holds a single entry and in_ready follows out_ready combinationally.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer;
    logic             out_xfer;

    // Status outputs decoded from the state register; out_data is the main register.
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        unique case (state_q)
            EMPTY:   level = 2'd0;
            ONE:     level = 2'd1;
            FULL:    level = 2'd2;
            default: level = 2'd0;
        endcase
        if (SKID) begin
            in_ready = (state_q != FULL);
        end else begin
            in_ready = !out_valid || out_ready;
        end
    end

    // Handshake qualifiers for this cycle.
    always_comb begin
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
    end

    // Next-state and data-load decisions; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer && SKID) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
